// File: rtl/kbd_event_queue.sv
// Keyboard event sequencer: turns the held-key level from kb_driver into discrete
// press/typematic-repeat events and queues them in a first-word-fall-through FIFO.
module kbd_event_queue #(
  parameter int DELAY_CYCLES  = 25000000,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ascii,
  input  logic [4:0]        flags,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [15:0]       rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [31:0]     DLY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0]     RPT_LAST = 32'(REPEAT_CYCLES - 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef struct packed {
    logic [4:0] flags;
    logic [7:0] ascii;
  } kev_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [7:0]  last_key, last_key_nxt;
  logic        push;

  // Event generation: new key pushes immediately, same key pushes on timer expiry.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    last_key_nxt = last_key;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (ascii != 8'd0) begin
          push         = 1'b1;
          last_key_nxt = ascii;
          timer_nxt    = '0;
          state_nxt    = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (ascii == 8'd0) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (ascii != last_key) begin
          push         = 1'b1;
          last_key_nxt = ascii;
          timer_nxt    = '0;
          state_nxt    = DELAY;
        end else if (timer == ((state == DELAY) ? DLY_LAST : RPT_LAST)) begin
          push      = 1'b1;
          timer_nxt = '0;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  kev_t              mem [DEPTH];
  kev_t              in_ev;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              pop, wr, drop;

  assign in_ev = {flags, ascii};
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign pop   = rd_en & ~empty;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign rd_data = empty ? 16'd0 : {3'b000, mem[rd_ptr]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      last_key <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      last_key <= last_key_nxt;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push beats a simultaneous clear so no overflow goes unseen.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_ev;
  end

endmodule

// File: doc/kbd_event_queue.md
Name: kbd_event_queue

Overview:
Keyboard event sequencer between kb_driver and the CPU's memory-mapped keyboard register. It converts the level-type "currently held key" output of kb_driver into discrete key events, adds typematic auto-repeat (initial delay, then periodic repeats), and buffers the events in a FIFO that the CPU pops one at a time. It replaces the ad-hoc repeat logic at the top level. The CPU sees events with first-word-fall-through semantics through memory_map.

Parameters:
DELAY_CYCLES, 25000000, clk cycles from first press to first repeat (500 ms at 50 MHz)
REPEAT_CYCLES, 12500000, clk cycles between repeats (250 ms at 50 MHz)
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries

Ports:
clk  in  1  CLOCK_50 domain clock
rst  in  1  synchronous reset, active-high
ascii  in  8  held-key ASCII from kb_driver; 0 = no key
flags  in  5  {is_error, is_special, is_capital, is_ctrl, is_shift}, synchronous to clk
rd_en  in  1  CPU pop strobe, one cycle per pop
clr_ovf  in  1  clears the sticky overflow flag
rd_data  out  16  {3'b0, flags, ascii} of the head entry; 16'd0 when empty
empty  out  1  FIFO holds 0 entries
full  out  1  FIFO holds 2**ADDR_W entries
count  out  ADDR_W+1  number of entries held, 0..16
overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (synchronous, rst=1 at posedge clk): FSM=IDLE, timer=0, read and write pointers=0, count=0, empty=1, full=0, overflow=0, rd_data=0. Reset during DELAY or REPEAT aborts the repeat. Entries already queued are discarded.
- FSM states and transitions:
  - IDLE:
    - ascii!=0: push {flags, ascii}, latch last_key=ascii, timer=0, go to DELAY.
  - DELAY:
    - ascii==0: go to IDLE; no push.
    - ascii!=0 and ascii!=last_key: push the new key, last_key=ascii, timer=0, stay in DELAY.
    - Otherwise, if timer==DELAY_CYCLES-1: push, timer=0, go to REPEAT.
    - Otherwise: timer+1.
  - REPEAT:
    - Same rules as DELAY, using REPEAT_CYCLES.
    - A changed key returns the FSM to DELAY.
- A push captures the flags and ascii values present in the same cycle.
- Push and pop timing:
  - A push at posedge N makes the entry visible on rd_data and deasserts empty from cycle N+1.
  - rd_data is combinational from the head entry (first-word-fall-through).
  - A pop (rd_en=1 and not empty) advances the head at that posedge.
  - rd_en while empty is ignored; no pointer or count change.
- Simultaneous push and pop:
  - Both take effect in the same cycle and count is unchanged.
  - When full, a push is accepted if rd_en pops in the same cycle.
  - When empty, only the push takes effect.
- Push while full with no pop: the entry is dropped, overflow is set to 1, and the FIFO is unchanged.
- Overflow flag: clr_ovf clears it. If a set event and clr_ovf occur in the same cycle, set wins.
- Pointers are ADDR_W bits and wrap modulo 16. count is ADDR_W+1 bits. full = (count==16), empty = (count==0).
- The timer is 32 bits and never exceeds max(DELAY_CYCLES, REPEAT_CYCLES)-1.

Test Plan:
- rst=1 for 2 cycles, then ascii=0x41 held for 3 cycles -> exactly one entry; count=1; rd_data=0x0041 from the cycle after the push; empty=0.
- DELAY_CYCLES=10, REPEAT_CYCLES=4, ascii=0x61 held for 30 cycles -> pushes at t=0, t=10, t=14, t=18, t=22, t=26; count=6.
- Key change: 0x61 for 5 cycles then 0x62 -> second push at the change cycle; the 0x62 repeat occurs 10 cycles after the change; no further 0x61 entries.
- Fill to 16 entries, push a 17th -> full=1, overflow=1, count=16, head unchanged. Then rd_en with a push in the same cycle -> count=16, overflow unchanged. Then clr_ovf -> overflow=0.
- rd_en on an empty FIFO for 3 cycles -> count=0, rd_data=0. Then push 0x0D with flags=5'b00001 -> rd_data=0x010D.
- rst asserted mid-REPEAT with 5 entries queued -> next cycle count=0, empty=1, FSM=IDLE. With the key still held after rst falls, one fresh push occurs.
